sram_arbiter: RTL and testbench

Two-port arbiter that shares the single SRAM-style port of the SDRAM controller (`ssdram`: addr/data/cs/oe/we) between the CPU bus (port A) and a secondary master (port B, e.g. DMA or video fetch). It latches each winning request, holds the memory controls stable for a fixed access window, captures read data, and returns a one-cycle acknowledge. It sits between `Microcomputer`'s SRAM signals and `ssdram`, in the `clk_ram` domain.

---
 rtl/sram_arbiter_if.sv | 48 ++++
 rtl/sram_arbiter.sv | 149 ++++++++++++++
 tb/tb_sram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Bundle of the two requester ports and the shared SRAM-style memory port of
// sram_arbiter. Signal suffixes are from the arbiter's point of view.
interface sram_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              a_req_i;
  logic              a_we_i;
  logic [ADDR_W-1:0] a_addr_i;
  logic [DATA_W-1:0] a_data_i;
  logic [DATA_W-1:0] a_data_o;
  logic              a_ack_o;

  logic              b_req_i;
  logic              b_we_i;
  logic [ADDR_W-1:0] b_addr_i;
  logic [DATA_W-1:0] b_data_i;
  logic [DATA_W-1:0] b_data_o;
  logic              b_ack_o;

  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              mem_cs_o;
  logic              mem_oe_o;
  logic              mem_we_o;

  logic              grant_o;
  logic              busy_o;

  modport slave (
    input  a_req_i, a_we_i, a_addr_i, a_data_i,
    input  b_req_i, b_we_i, b_addr_i, b_data_i,
    input  mem_data_i,
    output a_data_o, a_ack_o, b_data_o, b_ack_o,
    output mem_addr_o, mem_data_o, mem_cs_o, mem_oe_o, mem_we_o,
    output grant_o, busy_o
  );

  modport master (
    output a_req_i, a_we_i, a_addr_i, a_data_i,
    output b_req_i, b_we_i, b_addr_i, b_data_i,
    output mem_data_i,
    input  a_data_o, a_ack_o, b_data_o, b_ack_o,
    input  mem_addr_o, mem_data_o, mem_cs_o, mem_oe_o, mem_we_o,
    input  grant_o, busy_o
  );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one SRAM-style memory port between requesters A and B with a fixed
// access window. Define ARB_ROUND_ROBIN_EN for round-robin contention, else A has priority.
module sram_arbiter #(
  parameter int ADDR_W        = 19,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 6
) (
  input  logic          clock_i,
  input  logic          reset_i,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memData_q, memData_d;
  logic              memCs_q, memCs_d;
  logic              memOe_q, memOe_d;
  logic              memWe_q, memWe_d;
  logic [DATA_W-1:0] aData_q, aData_d;
  logic [DATA_W-1:0] bData_q, bData_d;
  logic              aAck_q, aAck_d;
  logic              bAck_q, bAck_d;
  logic              busy_q, busy_d;
  logic              winner;

`ifdef ARB_ROUND_ROBIN_EN
  // Last port served; resets to B so that A wins the first contention.
  logic rrLast_q, rrLast_d;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) rrLast_q <= 1'b1;
    else         rrLast_q <= rrLast_d;
  end

  assign winner = bus.b_req_i && (!bus.a_req_i || !rrLast_q);
`else
  assign winner = bus.b_req_i && !bus.a_req_i;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      count_q   <= '0;
      grant_q   <= 1'b0;
      memAddr_q <= '0;
      memData_q <= '0;
      memCs_q   <= 1'b0;
      memOe_q   <= 1'b0;
      memWe_q   <= 1'b0;
      aData_q   <= '0;
      bData_q   <= '0;
      aAck_q    <= 1'b0;
      bAck_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      grant_q   <= grant_d;
      memAddr_q <= memAddr_d;
      memData_q <= memData_d;
      memCs_q   <= memCs_d;
      memOe_q   <= memOe_d;
      memWe_q   <= memWe_d;
      aData_q   <= aData_d;
      bData_q   <= bData_d;
      aAck_q    <= aAck_d;
      bAck_q    <= bAck_d;
      busy_q    <= busy_d;
    end
  end

  // Every output is computed one cycle ahead so it leaves a register.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    grant_d   = grant_q;
    memAddr_d = memAddr_q;
    memData_d = memData_q;
    memCs_d   = 1'b0;
    memOe_d   = 1'b0;
    memWe_d   = 1'b0;
    aData_d   = aData_q;
    bData_d   = bData_q;
    aAck_d    = 1'b0;
    bAck_d    = 1'b0;
    busy_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rrLast_d  = rrLast_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.a_req_i || bus.b_req_i) begin
          grant_d   = winner;
          memAddr_d = winner ? bus.b_addr_i : bus.a_addr_i;
          memData_d = winner ? bus.b_data_i : bus.a_data_i;
          memWe_d   = winner ? bus.b_we_i : bus.a_we_i;
          memOe_d   = !(winner ? bus.b_we_i : bus.a_we_i);
          memCs_d   = 1'b1;
          count_d   = 4'(ACCESS_CYCLES - 1);
          busy_d    = 1'b1;
          state_d   = ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
          rrLast_d  = winner;
`endif
        end
      end
      ACCESS: begin
        busy_d = 1'b1;
        if (count_q == 4'd0) begin
          state_d = DONE;
          aAck_d  = !grant_q;
          bAck_d  = grant_q;
          if (!memWe_q) begin
            if (grant_q) bData_d = bus.mem_data_i;
            else         aData_d = bus.mem_data_i;
          end
        end else begin
          count_d = count_q - 4'd1;
          memCs_d = 1'b1;
          memWe_d = memWe_q;
          memOe_d = memOe_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_addr_o = memAddr_q;
  assign bus.mem_data_o = memData_q;
  assign bus.mem_cs_o   = memCs_q;
  assign bus.mem_oe_o   = memOe_q;
  assign bus.mem_we_o   = memWe_q;
  assign bus.a_data_o   = aData_q;
  assign bus.b_data_o   = bData_q;
  assign bus.a_ack_o    = aAck_q;
  assign bus.b_ack_o    = bAck_q;
  assign bus.grant_o    = grant_q;
  assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: an SRAM model answers the memory port and a
// scoreboard queue holds the expected acknowledge order and read data.
module tb_sram_arbiter;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;
  localparam int ACC    = 6;

  typedef struct {
    bit         port;
    bit         isRead;
    logic [7:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset;

  sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYCLES(ACC)) dut (
    .clock_i (clock),
    .reset_i (reset),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  exp_t       expQ[$];
  int         total = 0;
  int         bad = 0;
  int         cycleCnt = 0;
  bit         rrLastExp = 1'b1;
  bit [7:0]   memArr[256];
  bit         memValid[256];
  logic [7:0] expMem[int];

  function automatic logic [7:0] pattern(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  // Memory model aliases on the low address byte; unwritten locations return a pattern.
  assign bus.mem_data_i = memValid[bus.mem_addr_o[7:0]] ? memArr[bus.mem_addr_o[7:0]]
                                                         : pattern(bus.mem_addr_o[7:0]);

  initial begin
    forever begin
      @(posedge clock);
      cycleCnt = cycleCnt + 1;
      if (bus.mem_cs_o && bus.mem_we_o) begin
        memArr[bus.mem_addr_o[7:0]]   = bus.mem_data_o;
        memValid[bus.mem_addr_o[7:0]] = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] expRead(input logic [18:0] addr);
    int k = int'(addr[7:0]);
    return expMem.exists(k) ? expMem[k] : pattern(addr[7:0]);
  endfunction

  function automatic bit pickWinner(input bit aReq, input bit bReq);
    if (aReq && bReq) begin
`ifdef ARB_ROUND_ROBIN_EN
      return !rrLastExp;
`else
      return 1'b0;
`endif
    end
    return bReq && !aReq;
  endfunction

  task automatic pushExpect(input bit port, input bit we, input logic [18:0] addr,
                            input logic [7:0] data);
    exp_t e;
    e.port   = port;
    e.isRead = !we;
    e.data   = we ? 8'h00 : expRead(addr);
    if (we) expMem[int'(addr[7:0])] = data;
    expQ.push_back(e);
    rrLastExp = port;
  endtask

  task automatic applyStimulus(input bit port, input bit we, input logic [18:0] addr,
                               input logic [7:0] data, input bit push);
    if (!port) begin
      bus.a_we_i = we; bus.a_addr_i = addr; bus.a_data_i = data; bus.a_req_i = 1'b1;
    end else begin
      bus.b_we_i = we; bus.b_addr_i = addr; bus.b_data_i = data; bus.b_req_i = 1'b1;
    end
    if (push) pushExpect(port, we, addr, data);
  endtask

  task automatic waitAck(input bit port, input bit dropReq, input int budget,
                         output int ackCycle);
    bit seen = 1'b0;
    ackCycle = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (port ? bus.b_ack_o : bus.a_ack_o) begin
        seen = 1'b1;
        ackCycle = cycleCnt;
        if (dropReq) begin
          if (port) bus.b_req_i = 1'b0;
          else      bus.a_req_i = 1'b0;
        end
      end
    end
    checkOutput(port ? "ackBSeen" : "ackASeen", 32'(seen), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Ctl"}, 32'({bus.mem_cs_o, bus.mem_oe_o, bus.mem_we_o, bus.a_ack_o,
                                   bus.b_ack_o, bus.grant_o, bus.busy_o}), 32'd0);
    checkOutput({tag, "AddrData"}, 32'({bus.mem_addr_o, bus.mem_data_o}), 32'd0);
    checkOutput({tag, "PortData"}, 32'({bus.a_data_o, bus.b_data_o}), 32'd0);
  endtask

  // Scoreboard consumer: every acknowledge pops one expected access.
  initial begin
    bit         prevA = 1'b0;
    bit         prevB = 1'b0;
    logic [7:0] aExp = 8'h00;
    logic [7:0] bExp = 8'h00;
    exp_t       e;
    forever begin
      @(negedge clock);
      if (reset) begin
        aExp = 8'h00; bExp = 8'h00; prevA = 1'b0; prevB = 1'b0;
      end else begin
        if (bus.a_ack_o && bus.b_ack_o) checkOutput("dualAck", 32'd1, 32'd0);
        if (prevA && bus.a_ack_o) checkOutput("ackOnePulseA", 32'd1, 32'd0);
        if (prevB && bus.b_ack_o) checkOutput("ackOnePulseB", 32'd1, 32'd0);
        if (bus.a_ack_o || bus.b_ack_o) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedAck", 32'({bus.a_ack_o, bus.b_ack_o}), 32'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("ackPort", 32'(bus.b_ack_o), 32'(e.port));
            checkOutput("grantAtAck", 32'(bus.grant_o), 32'(e.port));
            if (e.isRead) begin
              if (e.port) bExp = e.data;
              else        aExp = e.data;
            end
            checkOutput("aDataAtAck", 32'(bus.a_data_o), 32'(aExp));
            checkOutput("bDataAtAck", 32'(bus.b_data_o), 32'(bExp));
          end
        end
        prevA = bus.a_ack_o;
        prevB = bus.b_ack_o;
      end
    end
  end

  initial begin
    int t1, t2, csCycles, ackIdx, gap, aDone, w, aLeft;
    int order[11];
    bit bPend, first, ackSeen;

    reset = 1'b1;
    bus.a_req_i = 0; bus.a_we_i = 0; bus.a_addr_i = '0; bus.a_data_i = '0;
    bus.b_req_i = 0; bus.b_we_i = 0; bus.b_addr_i = '0; bus.b_data_i = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkAllZero("reset");
    reset = 1'b0;
    @(negedge clock);

    // Single A write: exact control window and ack position.
    applyStimulus(1'b0, 1'b1, 19'h12345, 8'h55, 1'b1);
    @(posedge clock);
    #1;
    checkOutput("wrCtlAtE0", 32'({bus.mem_cs_o, bus.mem_we_o, bus.mem_oe_o, bus.busy_o,
                                  bus.grant_o}), 32'b11010);
    checkOutput("wrAddr", 32'(bus.mem_addr_o), 32'h12345);
    checkOutput("wrData", 32'(bus.mem_data_o), 32'h55);
    csCycles = 0;
    ackIdx = -1;
    for (int k = 0; k < 20 && ackIdx < 0; k++) begin
      @(negedge clock);
      if (bus.mem_cs_o && bus.mem_we_o && !bus.mem_oe_o && bus.mem_addr_o == 19'h12345 &&
          bus.mem_data_o == 8'h55) csCycles++;
      if (bus.a_ack_o) begin
        ackIdx = k;
        bus.a_req_i = 1'b0;
      end
    end
    checkOutput("wrCsCycles", 32'(csCycles), 32'd6);
    checkOutput("wrAckCycle", 32'(ackIdx), 32'd6);
    @(negedge clock);
    checkOutput("wrAckPulse", 32'(bus.a_ack_o), 32'd0);

    // Back-to-back A reads: cs gap and access period.
    applyStimulus(1'b0, 1'b0, 19'h12345, 8'h00, 1'b1);
    waitAck(1'b0, 1'b0, 20, t1);
    checkOutput("rdAData", 32'(bus.a_data_o), 32'h55);
    applyStimulus(1'b0, 1'b0, 19'h00010, 8'h00, 1'b1);
    gap = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.mem_cs_o) break;
      gap++;
      @(negedge clock);
    end
    checkOutput("b2bCsGapAtLeast2", 32'(gap >= 2), 32'd1);
    waitAck(1'b0, 1'b1, 20, t2);
    checkOutput("b2bPeriod", 32'(t2 - t1), 32'd8);
    checkOutput("bDataUntouched", 32'(bus.b_data_o), 32'h00);
    @(negedge clock);

    // Simultaneous requests, twice.
    for (int r = 0; r < 2; r++) begin
      first = pickWinner(1'b1, 1'b1);
      if (!first) begin
        applyStimulus(1'b0, 1'b1, 19'h00020, 8'(8'h11 + r), 1'b1);
        applyStimulus(1'b1, 1'b0, 19'h00030, 8'h00, 1'b1);
      end else begin
        applyStimulus(1'b1, 1'b0, 19'h00030, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b1, 19'h00020, 8'(8'h11 + r), 1'b1);
      end
      waitAck(first, 1'b1, 20, t1);
      waitAck(!first, 1'b1, 20, t2);
      @(negedge clock);
    end

    // Continuous A requests with B pending for ten A accesses.
    aLeft = 10;
    bPend = 1'b1;
    for (int k = 0; k < 11; k++) begin
      w = int'(pickWinner(aLeft > 0, bPend));
      order[k] = w;
      pushExpect(w[0], 1'b0, w[0] ? 19'h00030 : 19'h00010, 8'h00);
      if (w[0]) bPend = 1'b0;
      else      aLeft--;
    end
    applyStimulus(1'b0, 1'b0, 19'h00010, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 19'h00030, 8'h00, 1'b0);
    aDone = 0;
    for (int k = 0; k < 11; k++) begin
      if (order[k] == 0) aDone++;
      waitAck(order[k][0], order[k][0] || aDone == 10, 20, t1);
    end
    @(negedge clock);

    // Reset in the third ACCESS cycle of an A write.
    applyStimulus(1'b0, 1'b1, 19'h00040, 8'h77, 1'b0);
    @(posedge clock);
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b1;
    rrLastExp = 1'b1;
    #1;
    checkAllZero("midReset");
    bus.a_req_i = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    ackSeen = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (bus.a_ack_o || bus.b_ack_o) ackSeen = 1'b1;
    end
    checkOutput("noAckAfterReset", 32'(ackSeen), 32'd0);

    applyStimulus(1'b1, 1'b0, 19'h12345, 8'h00, 1'b1);
    waitAck(1'b1, 1'b1, 20, t1);
    checkOutput("bReadAfterReset", 32'(bus.b_data_o), 32'h55);
    checkOutput("aDataClearedByReset", 32'(bus.a_data_o), 32'h00);
    @(negedge clock);
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
